// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator: pixel-clock divider, h/v raster
// counters and an output pipeline of 1+OUT_DELAY stages for latency matching.
module vga_timing_gen #(
  parameter int CNT_W     = 11,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int PIX_DIV   = 1,
  parameter int OUT_DELAY = 0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_DE,
  output logic [CNT_W-1:0] o_Col,
  output logic [CNT_W-1:0] o_Row,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic             o_Pix_En
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int OW      = 2 * CNT_W + 6;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    cnt_t col;
    cnt_t row;
    logic ls;
    logic fs;
    logic pe;
  } out_t;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic       HS_ON    = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic       VS_ON    = (V_POL != 0) ? 1'b1 : 1'b0;
  localparam out_t       RST_VAL  = out_t'({~HS_ON, ~VS_ON, {(OW-2){1'b0}}});

  if ((longint'(H_TOTAL) >= (longint'(1) << CNT_W)) ||
      (longint'(V_TOTAL) >= (longint'(1) << CNT_W))) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end
  if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be 1..16");
  end
  if ((OUT_DELAY < 0) || (OUT_DELAY > 8)) begin : g_bad_delay
    $error("vga_timing_gen: OUT_DELAY must be 0..8");
  end

  logic [3:0] div_q, div_d;
  cnt_t       h_q, h_d;
  cnt_t       v_q, v_d;
  logic       tick_s;
  logic       de_s;
  out_t       st0_d;
  out_t       pipe_q [OUT_DELAY+1];

  assign tick_s = i_Enable && (div_q == DIV_LAST);
  assign de_s   = (h_q < H_ACT) && (v_q < V_ACT);

  // Next-state of the divider and the raster position.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (tick_s) begin
      div_d = 4'd0;
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + cnt_t'(1);
        end
      end else begin
        h_d = h_q + cnt_t'(1);
      end
    end else if (i_Enable) begin
      div_d = div_q + 4'd1;
    end else begin
      div_d = div_q;
    end
  end

  // Stage-0 output decode; strobes exist only on tick cycles, the rest hold when paused.
  always_comb begin
    st0_d    = pipe_q[0];
    st0_d.ls = 1'b0;
    st0_d.fs = 1'b0;
    st0_d.pe = 1'b0;
    if (i_Enable) begin
      st0_d.hs  = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_ON : ~HS_ON;
      st0_d.vs  = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_ON : ~VS_ON;
      st0_d.de  = de_s;
      st0_d.col = de_s ? h_q : '0;
      st0_d.row = de_s ? v_q : '0;
      st0_d.ls  = tick_s && (h_q == '0);
      st0_d.fs  = tick_s && (h_q == '0) && (v_q == '0);
      st0_d.pe  = tick_s;
    end else begin
      st0_d.pe = 1'b0;
    end
  end

  // Raster counters.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      div_q <= 4'd0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Output pipeline: stage 0 plus OUT_DELAY identical delay stages.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i <= OUT_DELAY; i++) begin
        pipe_q[i] <= RST_VAL;
      end
    end else begin
      pipe_q[0] <= st0_d;
      for (int i = 1; i <= OUT_DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign o_HSync       = pipe_q[OUT_DELAY].hs;
  assign o_VSync       = pipe_q[OUT_DELAY].vs;
  assign o_DE          = pipe_q[OUT_DELAY].de;
  assign o_Col         = pipe_q[OUT_DELAY].col;
  assign o_Row         = pipe_q[OUT_DELAY].row;
  assign o_Line_Start  = pipe_q[OUT_DELAY].ls;
  assign o_Frame_Start = pipe_q[OUT_DELAY].fs;
  assign o_Pix_En      = pipe_q[OUT_DELAY].pe;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations driven from a shared enable/reset,
// compared every cycle against an arithmetic raster model, plus timing spot checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] col;
    logic [10:0] row;
    logic        ls;
    logic        fs;
    logic        pe;
  } ov_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, div, dly;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic        hs_w [4];
  logic        vs_w [4];
  logic        de_w [4];
  logic        ls_w [4];
  logic        fs_w [4];
  logic        pe_w [4];
  logic [10:0] col_w [4];
  logic [10:0] row_w [4];

  vga_timing_gen u_def (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .o_HSync(hs_w[0]), .o_VSync(vs_w[0]), .o_DE(de_w[0]), .o_Col(col_w[0]), .o_Row(row_w[0]),
    .o_Line_Start(ls_w[0]), .o_Frame_Start(fs_w[0]), .o_Pix_En(pe_w[0])
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)) u_small (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .o_HSync(hs_w[1]), .o_VSync(vs_w[1]), .o_DE(de_w[1]), .o_Col(col_w[1]), .o_Row(row_w[1]),
    .o_Line_Start(ls_w[1]), .o_Frame_Start(fs_w[1]), .o_Pix_En(pe_w[1])
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIX_DIV(3)) u_div3 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .o_HSync(hs_w[2]), .o_VSync(vs_w[2]), .o_DE(de_w[2]), .o_Col(col_w[2]), .o_Row(row_w[2]),
    .o_Line_Start(ls_w[2]), .o_Frame_Start(fs_w[2]), .o_Pix_En(pe_w[2])
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .OUT_DELAY(4)) u_dly4 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .o_HSync(hs_w[3]), .o_VSync(vs_w[3]), .o_DE(de_w[3]), .o_Col(col_w[3]), .o_Row(row_w[3]),
    .o_Line_Start(ls_w[3]), .o_Frame_Start(fs_w[3]), .o_Pix_En(pe_w[3])
  );

  cfg_t cfg [4];
  int   ecnt [4];
  ov_t  st0 [4];
  ov_t  hist [4][$];
  ov_t  logs [4][$];
  bit   logging = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic ov_t rst_val(input cfg_t c);
    ov_t o = '0;
    o.hs = (c.hpol == 0);
    o.vs = (c.vpol == 0);
    return o;
  endfunction

  // Output for pixel number p (ticks since reset), straight from the raster rules.
  function automatic ov_t stage_val(input cfg_t c, input int p, input bit tick);
    ov_t o;
    int  ht = c.ha + c.hf + c.hs + c.hb;
    int  vt = c.va + c.vf + c.vs + c.vb;
    int  h  = p % ht;
    int  v  = (p / ht) % vt;
    bit  hon = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    bit  von = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    o.hs  = hon ? (c.hpol != 0) : (c.hpol == 0);
    o.vs  = von ? (c.vpol != 0) : (c.vpol == 0);
    o.de  = (h < c.ha) && (v < c.va);
    o.col = o.de ? 11'(h) : 11'd0;
    o.row = o.de ? 11'(v) : 11'd0;
    o.ls  = tick && (h == 0);
    o.fs  = tick && (h == 0) && (v == 0);
    o.pe  = tick;
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      ecnt[k] = 0;
      st0[k]  = rst_val(cfg[k]);
      hist[k].delete();
    end
  endtask

  task automatic model_edge(input int k, input bit e);
    bit tick;
    if (e) begin
      tick    = (ecnt[k] % cfg[k].div) == (cfg[k].div - 1);
      st0[k]  = stage_val(cfg[k], ecnt[k] / cfg[k].div, tick);
      ecnt[k] = ecnt[k] + 1;
    end else begin
      st0[k].ls = 1'b0;
      st0[k].fs = 1'b0;
      st0[k].pe = 1'b0;
    end
    hist[k].push_back(st0[k]);
    if (hist[k].size() > cfg[k].dly + 1) void'(hist[k].pop_front());
  endtask

  function automatic ov_t expected(input int k);
    if (hist[k].size() == cfg[k].dly + 1) return hist[k][0];
    return rst_val(cfg[k]);
  endfunction

  function automatic ov_t actual(input int k);
    return {hs_w[k], vs_w[k], de_w[k], col_w[k], row_w[k], ls_w[k], fs_w[k], pe_w[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 4; k++) model_edge(k, en);
    cyc++;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out%0d", k), longint'(actual(k)), longint'(expected(k)));
      if (logging) logs[k].push_back(actual(k));
    end
  endtask

  initial begin
    int  cnt;
    int  fs_i [$];
    int  fs3  [$];
    int  fs4  [$];
    int  ls_i [$];
    int  t_fs;
    bit  found;
    logic [7:0] hpat;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 0};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 1, 0};
    cfg[2] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 3, 0};
    cfg[3] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 1, 4};
    model_reset();

    repeat (3) step();
    check("rst_hs_def", hs_w[0], 1);
    check("rst_hs_small", hs_w[1], 0);
    rst = 1'b0;
    en  = 1'b1;

    logging = 1'b1;
    repeat (1700) step();
    logging = 1'b0;

    // Default mode: line period, HSync placement and width, DE count on line 0.
    for (int i = 0; i < logs[0].size(); i++) if (logs[0][i].ls) ls_i.push_back(i);
    check("def_ls_count", ls_i.size(), 3);
    if (ls_i.size() >= 3) begin
      check("def_line_period0", ls_i[1] - ls_i[0], 800);
      check("def_line_period1", ls_i[2] - ls_i[1], 800);
    end
    check("def_ls_first", logs[0][0].ls, 1);
    check("def_hs_655", logs[0][655].hs, 1);
    check("def_hs_656", logs[0][656].hs, 0);
    check("def_hs_751", logs[0][751].hs, 0);
    check("def_hs_752", logs[0][752].hs, 1);
    cnt = 0;
    for (int i = 0; i < 800; i++) cnt += (logs[0][i].hs == 1'b0) ? 1 : 0;
    check("def_hs_width", cnt, 96);
    cnt = 0;
    for (int i = 0; i < 800; i++) cnt += logs[0][i].de ? 1 : 0;
    check("def_de_line", cnt, 640);

    // Small mode: column sequence, sync windows, frame period and DE area.
    for (int i = 0; i < logs[1].size(); i++) if (logs[1][i].fs) fs_i.push_back(i);
    check("small_fs_count", fs_i.size(), 36);
    if (fs_i.size() >= 2) check("small_frame_period", fs_i[1] - fs_i[0], 48);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("small_col%0d", i), logs[1][i].col, (i < 4) ? i : 0);
      hpat[i] = logs[1][i].hs;
    end
    check("small_hs_pattern", hpat, 8'b0110_0000);
    cnt = 0;
    for (int i = 0; i < 48; i++) cnt += logs[1][i].vs ? 1 : 0;
    check("small_vs_count", cnt, 8);
    check("small_vs_line4", {logs[1][31].vs, logs[1][32].vs, logs[1][40].vs}, 3'b010);
    cnt = 0;
    for (int i = 0; i < 48; i++) cnt += logs[1][i].de ? 1 : 0;
    check("small_de_count", cnt, 12);

    // PIX_DIV=3: 3-cycle hold, one-cycle strobes, 144-cycle frame.
    for (int i = 0; i < logs[2].size(); i++) if (logs[2][i].fs) fs3.push_back(i);
    check("div3_fs_first", (fs3.size() > 0) ? fs3[0] : -1, 2);
    if (fs3.size() >= 2) check("div3_frame_period", fs3[1] - fs3[0], 144);
    check("div3_fs_width", {logs[2][1].fs, logs[2][2].fs, logs[2][3].fs}, 3'b010);
    check("div3_col_hold", {logs[2][3].col, logs[2][5].col, logs[2][6].col},
          {11'd1, 11'd1, 11'd2});
    cnt = 0;
    for (int i = 0; i < 144; i++) cnt += logs[2][i].pe ? 1 : 0;
    check("div3_pe_count", cnt, 48);

    // OUT_DELAY=4 against OUT_DELAY=0 from the same reset.
    for (int i = 0; i < logs[3].size(); i++) if (logs[3][i].fs) fs4.push_back(i);
    if ((fs4.size() > 0) && (fs_i.size() > 0)) check("dly4_shift", fs4[0] - fs_i[0], 4);
    else check("dly4_fs_seen", fs4.size(), 36);

    // Pause 10 cycles at h=2,v=1 of the small mode.
    found = 1'b0;
    t_fs  = 0;
    for (int i = 0; (i < 100) && !found; i++) begin
      step();
      if (fs_w[1]) begin found = 1'b1; t_fs = cyc; end
    end
    check("pause_sync_fs", found, 1);
    for (int i = 0; (i < 100) && ((ecnt[1] % 48) != 10); i++) step();
    check("pause_pos", ecnt[1] % 48, 10);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pause_pe", pe_w[1], 0);
    end
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; (i < 100) && !found; i++) begin
      step();
      if (fs_w[1]) found = 1'b1;
    end
    check("pause_frame_period", cyc - t_fs, 58);

    // Randomised enable.
    repeat (800) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;

    // Asynchronous reset between edges at h=6,v=2 of the small mode.
    for (int i = 0; (i < 100) && ((ecnt[1] % 48) != 22); i++) step();
    check("arst_pos", ecnt[1] % 48, 22);
    #2 rst = 1'b1;
    #1;
    check("arst_hs", hs_w[1], 0);
    check("arst_vs", vs_w[1], 0);
    check("arst_de", de_w[1], 0);
    check("arst_col", col_w[1], 0);
    step();
    rst = 1'b0;
    step();
    check("arst_fs", fs_w[1], 1);
    check("arst_fs_col", col_w[1], 0);
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
